// File: rtl/bm_pkg.sv
// Shared types and sizing helpers for the bm serial transmitter.
package bm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // One counter serves both the bit count and the gap count, so it must cover the larger span.
  function automatic int unsigned cnt_width(input int unsigned w, input int unsigned g);
    int unsigned m;
    m = (w > g + 1) ? w : g + 1;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_GAP_CYCLES = 1;
  localparam int unsigned DEF_CNT_W      = cnt_width(DEF_WIDTH, DEF_GAP_CYCLES);

endpackage

// File: rtl/bm_mod_counter.sv
// Loadable down-counter that saturates at zero; load wins over decrement.
module bm_mod_counter #(
  parameter int CW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bm_serial_tx.sv
// Parallel-to-serial transmitter: first bit on dout the cycle after the accepting edge.
// All outputs except load_ready are registered so the downstream sampler sees no glitches.
module bm_serial_tx #(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter int   GAP_CYCLES = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             c,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_par,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             frame_done
);

  import bm_pkg::*;

  localparam int CW = cnt_width(WIDTH, GAP_CYCLES);
  localparam logic [CW-1:0] SHIFT_LD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LD   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             fs_q, fs_d;
  logic             fd_q, fd_d;

  logic             cnt_load, cnt_en, cnt_zero;
  logic [CW-1:0]    cnt_val, cnt;
  logic [WIDTH-1:0] src, src_next;
  logic             src_head;

  bm_mod_counter #(.CW(CW)) u_cnt (
    .clk_i      (c),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  // The bit leaving next comes from din_par on the accepting edge, otherwise from the shift register.
  always_comb begin
    src      = (state_q == IDLE) ? din_par : sreg_q;
    src_head = (MSB_FIRST != 0) ? src[WIDTH-1] : src[0];
    src_next = (MSB_FIRST != 0) ? {src[WIDTH-2:0], 1'b0} : {1'b0, src[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    dout_d   = IDLE_LEVEL;
    vld_d    = 1'b0;
    fs_d     = 1'b0;
    fd_d     = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = SHIFT_LD;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          state_d  = SHIFT;
          cnt_load = 1'b1;
          cnt_val  = SHIFT_LD;
          sreg_d   = src_next;
          dout_d   = src_head;
          vld_d    = 1'b1;
          fs_d     = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_zero) begin
          if (GAP_CYCLES > 0) begin
            state_d  = GAP;
            cnt_load = 1'b1;
            cnt_val  = GAP_LD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_en = 1'b1;
          sreg_d = src_next;
          dout_d = src_head;
          vld_d  = 1'b1;
          fd_d   = (cnt == CW'(1));
        end
      end
      GAP: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      dout_q  <= IDLE_LEVEL;
      vld_q   <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
    end
  end

  assign load_ready  = (state_q == IDLE);
  assign dout        = dout_q;
  assign dout_valid  = vld_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;

endmodule

// File: tb/tb_bm_serial_tx.sv
// Directed bench for bm_serial_tx: MSB-first/gap 1, LSB-first, and gap 0 instances plus a 3-bit receiver model.
module tb_bm_serial_tx;

  logic       c = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din_w [3];
  logic [2:0] lv_w;
  logic [2:0] rdy_w, dout_w, vld_w, fs_w, fd_w;
  logic [2:0] sh3 = 3'b000;
  int         nvec = 0;
  int         nmis = 0;

  always #5 c = ~c;

  bm_serial_tx #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(1), .IDLE_LEVEL(1'b0)) u_msb (
    .c(c), .rst(rst), .din_par(din_w[0]), .load_valid(lv_w[0]), .load_ready(rdy_w[0]),
    .dout(dout_w[0]), .dout_valid(vld_w[0]), .frame_start(fs_w[0]), .frame_done(fd_w[0]));

  bm_serial_tx #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(1), .IDLE_LEVEL(1'b0)) u_lsb (
    .c(c), .rst(rst), .din_par(din_w[1]), .load_valid(lv_w[1]), .load_ready(rdy_w[1]),
    .dout(dout_w[1]), .dout_valid(vld_w[1]), .frame_start(fs_w[1]), .frame_done(fd_w[1]));

  bm_serial_tx #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_g0 (
    .c(c), .rst(rst), .din_par(din_w[2]), .load_valid(lv_w[2]), .load_ready(rdy_w[2]),
    .dout(dout_w[2]), .dout_valid(vld_w[2]), .frame_start(fs_w[2]), .frame_done(fd_w[2]));

  // Downstream 3-bit serial-in stage fed by the MSB-first instance; bit 2 holds the oldest bit.
  always @(posedge c) sh3 <= {sh3[1:0], dout_w[0]};

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int d, input string tag, input logic exp_rdy);
    chk($sformatf("%s_d%0d_dout", tag, d), {7'd0, dout_w[d]}, 8'd0);
    chk($sformatf("%s_d%0d_valid", tag, d), {7'd0, vld_w[d]}, 8'd0);
    chk($sformatf("%s_d%0d_fs", tag, d), {7'd0, fs_w[d]}, 8'd0);
    chk($sformatf("%s_d%0d_fd", tag, d), {7'd0, fd_w[d]}, 8'd0);
    chk($sformatf("%s_d%0d_ready", tag, d), {7'd0, rdy_w[d]}, {7'd0, exp_rdy});
  endtask

  // Checks the first n bits of a frame, starting in the cycle that carries bit 0.
  task automatic run_bits(input int d, input logic [7:0] w, input bit msb, input int n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("d%0d_w%0h_dout_k%0d", d, w, k), {7'd0, dout_w[d]}, {7'd0, msb ? w[7-k] : w[k]});
      chk($sformatf("d%0d_w%0h_valid_k%0d", d, w, k), {7'd0, vld_w[d]}, 8'd1);
      chk($sformatf("d%0d_w%0h_fs_k%0d", d, w, k), {7'd0, fs_w[d]}, {7'd0, k == 0});
      chk($sformatf("d%0d_w%0h_fd_k%0d", d, w, k), {7'd0, fd_w[d]}, {7'd0, k == 7});
      chk($sformatf("d%0d_w%0h_ready_k%0d", d, w, k), {7'd0, rdy_w[d]}, 8'd0);
      tick();
    end
  endtask

  initial begin
    lv_w = 3'b000;
    for (int i = 0; i < 3; i++) din_w[i] = 8'h00;

    #1;
    for (int d = 0; d < 3; d++) chk_idle(d, "reset", 1'b1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // MSB-first A5, with a new word offered while the frame is in flight
    din_w[0] = 8'hA5;
    lv_w[0]  = 1'b1;
    tick();
    din_w[0] = 8'hFF;
    run_bits(0, 8'hA5, 1'b1, 8);
    chk_idle(0, "gap_a5", 1'b0);
    tick();
    chk("idle_a5_ready", {7'd0, rdy_w[0]}, 8'd1);
    chk("idle_a5_valid", {7'd0, vld_w[0]}, 8'd0);
    tick();
    lv_w[0] = 1'b0;
    run_bits(0, 8'hFF, 1'b1, 8);
    chk_idle(0, "gap_ff", 1'b0);
    tick();
    chk_idle(0, "idle_ff", 1'b1);
    tick();
    chk_idle(0, "idle_ff2", 1'b1);

    // Three bits of A5 reach the receiver, then reset strikes between edges
    din_w[0] = 8'hA5;
    lv_w[0]  = 1'b1;
    tick();
    lv_w[0] = 1'b0;
    run_bits(0, 8'hA5, 1'b1, 3);
    chk("rx3_bits", {5'd0, sh3}, 8'h05);
    #3 rst = 1'b1;
    #1;
    chk_idle(0, "midrst", 1'b1);
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle(0, $sformatf("postrst%0d", i), 1'b1);
    end
    din_w[0] = 8'h81;
    lv_w[0]  = 1'b1;
    tick();
    lv_w[0] = 1'b0;
    run_bits(0, 8'h81, 1'b1, 8);
    chk_idle(0, "gap_81", 1'b0);

    // LSB-first 1E
    din_w[1] = 8'h1E;
    lv_w[1]  = 1'b1;
    tick();
    lv_w[1] = 1'b0;
    run_bits(1, 8'h1E, 1'b0, 8);
    chk_idle(1, "gap_1e", 1'b0);
    tick();
    chk_idle(1, "idle_1e", 1'b1);

    // Gap-free back-to-back F0 then 0F with load_valid held
    din_w[2] = 8'hF0;
    lv_w[2]  = 1'b1;
    tick();
    din_w[2] = 8'h0F;
    run_bits(2, 8'hF0, 1'b1, 8);
    chk_idle(2, "b2b_idle", 1'b1);
    tick();
    lv_w[2] = 1'b0;
    run_bits(2, 8'h0F, 1'b1, 8);
    chk_idle(2, "b2b_end", 1'b1);
    tick();
    chk_idle(2, "b2b_end2", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/bm_serial_tx.md
Name: bm_serial_tx

Overview:
- Parallel-to-serial transmitter (PISO) directly upstream of the team's 3-bit serial-in shift stage; its dout drives that stage's din on the same clock.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, with frame-boundary strobes and a programmable idle gap between words.

Parameters:
- WIDTH, 8: word length in bits; legal range ≥ 2.
- MSB_FIRST, 1: 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.
- GAP_CYCLES, 1: idle cycles forced between consecutive frames; 0 allowed.
- IDLE_LEVEL, 0: value driven on dout when no frame is active.

Ports:
- c  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din_par  input  WIDTH  parallel word to transmit.
- load_valid  input  1  din_par holds a word to send.
- load_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial data, registered.
- dout_valid  output  1  dout carries a frame bit this cycle.
- frame_start  output  1  dout carries the first bit of a frame.
- frame_done  output  1  dout carries the last bit of a frame.

Behaviour:
- Clock is c. Reset is asynchronous and active-high (rst).
- States: IDLE, SHIFT, GAP.
- While rst=1 or immediately after reset:
  - state=IDLE, dout=IDLE_LEVEL, dout_valid=0, frame_start=0, frame_done=0.
  - Shift register and bit counter are cleared.
  - load_ready=1.
  - No handshake can complete while rst is high.
- load_ready is combinational: it is 1 exactly when state=IDLE.
- Handshake: a word is accepted at a rising edge where load_valid=1 and load_ready=1.
  - din_par is captured into the internal shift register at that edge.
  - Later changes on din_par do not affect the frame in flight.
- load_valid is ignored when load_ready=0; there is no queueing. The upstream source must hold the word until it sees ready.
- Latency: the first bit appears on dout in the cycle immediately after the accepting edge.
- SHIFT state:
  - Lasts exactly WIDTH cycles; bit counter runs 0..WIDTH-1, width $clog2(WIDTH).
  - Cycle k (k=0..WIDTH-1) drives dout with bit WIDTH-1-k when MSB_FIRST=1, or bit k when MSB_FIRST=0.
  - dout_valid=1 throughout.
  - frame_start=1 only at k=0; frame_done=1 only at k=WIDTH-1.
- After the last bit:
  - If GAP_CYCLES>0: go to GAP for exactly GAP_CYCLES cycles, with dout=IDLE_LEVEL, dout_valid=0, load_ready=0, then return to IDLE.
  - If GAP_CYCLES=0: go straight to IDLE.
- Back-to-back throughput: one frame every WIDTH+GAP_CYCLES+1 cycles (one cycle spent in IDLE for the handshake).
- IDLE: dout=IDLE_LEVEL; all strobes low.
- Reset mid-frame (any state): abort immediately and asynchronously to the reset values above. Partially sent bits are lost; no frame_done is issued.
- Downstream contract: the 3-bit receiver samples dout every edge, so dout must be glitch-free. All outputs except load_ready come from flops.

Decomposition:
- Package bm_pkg:
  - state typedef (IDLE, SHIFT, GAP) with 2-bit encoding.
  - localparam for the counter width, derived via $clog2 of max(WIDTH, GAP_CYCLES+1).
- One sub-module: bm_mod_counter, a loadable down-counter shared by the SHIFT bit count and the GAP count.
- FSM, shift register and output flops stay in bm_serial_tx.

Test Plan:
- Basic MSB-first: WIDTH=8, MSB_FIRST=1, GAP_CYCLES=1; load 8'hA5 → dout = 1,0,1,0,0,1,0,1 over cycles 1..8 after the handshake.
  - frame_start only at cycle 1; frame_done only at cycle 8.
  - load_ready=0 for cycles 1..9 (8 shift cycles plus 1 gap), =1 at cycle 10.
- LSB-first: MSB_FIRST=0; load 8'h1E → dout = 0,1,1,1,1,0,0,0 over cycles 1..8.
- Ignored load and held data: while in SHIFT, assert load_valid with 8'hFF and change din_par → current frame unchanged, no second frame starts.
  - Holding load_valid into IDLE then sends 8'hFF starting exactly 1 cycle after load_ready rises.
- Back-to-back with GAP_CYCLES=0: load 8'hF0 then 8'h0F with load_valid held high → bits 1111 0000, then one IDLE cycle with dout=0 and dout_valid=0, then 0000 1111.
- Reset mid-frame: assert rst asynchronously between edges after 3 bits of 8'hA5 → dout=0, dout_valid=0, load_ready=1 immediately, with no frame_done.
  - A new 8'h81 loaded after reset is sent cleanly: 1,0,0,0,0,0,0,1.
- Chained with the downstream 3-bit stage: send 8'hA5 MSB-first → after the third bit, the downstream parallel outputs (first-received bit to last) read 1,0,1.
